pad_in_conditioner: RTL and testbench

PAD_IN_CONDITIONER -- requirements
Module: pad_in_conditioner

---
 rtl/pad_in_conditioner.sv | 109 ++++++++++
 tb/tb_pad_in_conditioner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_in_conditioner.sv
// Pad input conditioner: synchroniser, optional inversion, per-channel debounce and edge pulses.
// Define PAD_IN_EVENT_LATCH_EN to build the sticky edge-event register and its interrupt.
module pad_in_conditioner #(
  parameter int               NumIn          = 16,
  parameter int               SyncStages     = 2,
  parameter int               DebounceCycles = 1000,
  parameter logic [NumIn-1:0] InvertMask     = '0,
  parameter logic [NumIn-1:0] ResetVal       = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [NumIn-1:0] pad_i,
  input  logic [NumIn-1:0] rise_en_i,
  input  logic [NumIn-1:0] fall_en_i,
  input  logic [NumIn-1:0] clr_i,
  output logic [NumIn-1:0] level_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o,
  output logic [NumIn-1:0] event_o,
  output logic             irq_o
);

  logic [NumIn-1:0] sync_q [SyncStages];
  logic [NumIn-1:0] s;
  logic [NumIn-1:0] level_d, level_q, level_dly_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SyncStages-1] ^ InvertMask;

  if (DebounceCycles == 0) begin : g_bypass
    assign level_d = s;
  end else begin : g_debounce
    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntTerm = CntW'(DebounceCycles - 1);

    logic [CntW-1:0] cnt_d [NumIn];
    logic [CntW-1:0] cnt_q [NumIn];

    // A channel only moves after s has disagreed with level for DebounceCycles straight cycles.
    always_comb begin
      level_d = level_q;
      for (int i = 0; i < NumIn; i++) begin
        cnt_d[i] = '0;
        if (s[i] != level_q[i]) begin
          if (cnt_q[i] == CntTerm) level_d[i] = s[i];
          else                     cnt_d[i]   = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < NumIn; i++) cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The delayed copy resets to the same value as level so reset release never pulses.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      level_q     <= ResetVal;
      level_dly_q <= ResetVal;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_dly_q;
  assign fall_o  = ~level_q & level_dly_q;

`ifdef PAD_IN_EVENT_LATCH_EN
  logic [NumIn-1:0] event_d, event_q;
  logic             irq_q;

  // A new capture in the same cycle as a clear takes priority.
  assign event_d = (event_q & ~clr_i) | (rise_o & rise_en_i) | (fall_o & fall_en_i);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      irq_q   <= |event_d;
    end
  end

  assign event_o = event_q;
  assign irq_o   = irq_q;
`else
  logic unused_event_inputs;
  assign unused_event_inputs = ^{rise_en_i, fall_en_i, clr_i};
  assign event_o = '0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Self-checking bench for pad_in_conditioner: directed scenarios plus randomized traffic vs a history-based model.
module tb_pad_in_conditioner;
  localparam int         N  = 4;
  localparam int         SS = 2;
  localparam int         DC = 4;
  localparam logic [3:0] IM = 4'b1000;
  localparam logic [3:0] RV = 4'b1000;
`ifdef PAD_IN_EVENT_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] pad = '0, ren = '0, fen = '0, clr = '0;
  logic [3:0] level_o, rise_o, fall_o, event_o;
  logic       irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pad_in_conditioner #(
    .NumIn(N), .SyncStages(SS), .DebounceCycles(DC), .InvertMask(IM), .ResetVal(RV)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .pad_i(pad), .rise_en_i(ren), .fall_en_i(fen),
    .clr_i(clr), .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o),
    .irq_o(irq_o)
  );

  // Reference: level flips once the last DC synchronised samples all disagree with it.
  logic [3:0] padh[$];
  logic [3:0] shist[$];
  logic [3:0] m_level = RV, m_prev = RV, m_ev = '0;
  logic       m_irq = 1'b0;

  always @(posedge clk) begin
    logic [3:0] s, differ, rc, fc;
    if (!rst_n) begin
      padh = {};
      shist = {};
      repeat (SS) padh.push_back(4'b0000);
      repeat (DC) shist.push_back(RV);
      m_level = RV; m_prev = RV; m_ev = '0; m_irq = 1'b0;
    end else begin
      rc = m_level & ~m_prev;
      fc = ~m_level & m_prev;
      padh.push_back(pad);
      if (padh.size() > SS + 1) void'(padh.pop_front());
      s = padh[0] ^ IM;
      shist.push_back(s);
      if (shist.size() > DC) void'(shist.pop_front());
      differ = '1;
      foreach (shist[k]) differ &= (shist[k] ^ m_level);
      if (LATCH) m_ev = (m_ev & ~clr) | (rc & ren) | (fc & fen);
      else       m_ev = '0;
      m_irq  = |m_ev;
      m_prev = m_level;
      m_level = m_level ^ differ;
    end
  end

  function automatic logic [16:0] model_vec();
    return {m_level, m_level & ~m_prev, ~m_level & m_prev, m_ev, m_irq};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; pad = '0; ren = '0; fen = '0; clr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    rst_n = 1'b0; pad = '0; ren = '0; fen = '0; clr = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    obs = {level_o, rise_o, fall_o, event_o, irq_o};
    if (obs !== {4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs, {4'b1000, 13'h0});
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      obs = {level_o, rise_o, fall_o, event_o, irq_o};
      n_tests++;
      if (obs !== {4'b1000, 13'h0000} || obs !== model_vec()) begin
        n_fail++; $display("FAIL reset_release c=%0d: got %h want %h", c, obs, model_vec());
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [1:0] obs, exp;
    apply_reset();
    pad = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      obs = {level_o[0], rise_o[0]};
      exp = {(c >= 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0};
      n_tests++;
      if (obs !== exp || {level_o, rise_o, fall_o} !== model_vec()[16:5]) begin
        n_fail++; $display("FAIL clean_rise c=%0d: got lvl/rise %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] obs, exp;
    apply_reset();
    pad = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) pad = 4'b0000;
      obs = {level_o[1], rise_o[1]};
      n_tests++;
      if (obs !== 2'b00) begin
        n_fail++; $display("FAIL glitch_short c=%0d: got lvl/rise %b want 00", c, obs);
      end
    end
    pad = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) pad = 4'b0000;
      obs = {level_o[1], rise_o[1]};
      exp = {(c >= 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL glitch_min c=%0d: got lvl/rise %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_invert_fall_event();
    logic [3:0] obs, exp;
    apply_reset();
    fen = 4'b1000;
    pad = 4'b1000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      obs = {level_o[3], fall_o[3], event_o[3], irq_o};
      exp = {(c >= 6) ? 1'b0 : 1'b1, (c == 6) ? 1'b1 : 1'b0,
             (c >= 7) ? LATCH : 1'b0, (c >= 7) ? LATCH : 1'b0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL invert_fall c=%0d: got lvl/fall/ev/irq %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_clr();
    logic [1:0] obs, exp;
    ren = 4'b1000;
    pad = 4'b0000;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      clr = '0;
      if (c == 6) begin
        n_tests++;
        if (rise_o[3] !== 1'b1) begin
          n_fail++; $display("FAIL clr_rise_pulse: got %b want 1", rise_o[3]);
        end
        clr = 4'b1000;
      end
      if (c == 7) begin
        obs = {event_o[3], irq_o}; exp = {LATCH, LATCH};
        n_tests++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL clr_set_wins: got ev/irq %b want %b", obs, exp);
        end
        clr = 4'b1000;
      end
      if (c == 8) begin
        obs = {event_o[3], irq_o};
        n_tests++;
        if (obs !== 2'b00) begin
          n_fail++; $display("FAIL clr_alone: got ev/irq %b want 00", obs);
        end
      end
    end
    ren = '0;
  endtask

  task automatic test_reset_mid_count();
    logic obs, exp;
    apply_reset();
    pad = 4'b0100;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (level_o !== 4'b1000 || rise_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_hold: got lvl %b rise %b want 1000 0000", level_o, rise_o);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      obs = level_o[2];
      exp = (c >= 6) ? 1'b1 : 1'b0;
      n_tests++;
      if (obs !== exp || rise_o[2] !== ((c == 6) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL reset_mid_restart c=%0d: got lvl %b rise %b want %b", c, obs, rise_o[2], exp);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] obs;
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      obs = {level_o, rise_o, fall_o, event_o, irq_o};
      n_tests++;
      if (obs !== model_vec()) begin
        n_fail++; errs++;
        if (errs <= 10) $display("FAIL random c=%0d: got %h want %h", c, obs, model_vec());
      end
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) pad[i] = ~pad[i];
      if ($urandom_range(0, 15) == 0) pad = ~pad;
      ren = 4'($urandom);
      fen = 4'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
    end
    rst_n = 1'b1; clr = '0;
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_invert_fall_event();
    test_clr();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
